bit_serial_subtractor: RTL and testbench

BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

---
 rtl/bit_serial_subtractor.sv | 94 +++++++++
 tb/tb_bit_serial_subtractor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: computes ain - bin - bi one bit per clock, LSB first,
// then presents diff/bout/ovf/zero with a one-cycle done pulse.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             bi,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh;
  logic [WIDTH-1:0] a_nx, b_nx, d_nx;
  logic [CW-1:0]    cnt;
  logic             br, br_nx, d_bit;
  logic             accept, last;

  // Operands shift right so the bit at index cnt is always at position 0;
  // the difference fills in from the MSB end so it is aligned after WIDTH steps.
  always_comb begin
    accept = ((state == IDLE) || (state == DONE)) && start;
    last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    d_bit  = a_sh[0] ^ b_sh[0] ^ br;
    br_nx  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    a_nx   = a_sh >> 1;
    b_nx   = b_sh >> 1;
    d_nx   = d_sh >> 1;
    d_nx[WIDTH-1] = d_bit;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = DONE;
      DONE:    state_nx = start ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      br    <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sh <= ain;
        b_sh <= bin;
        br   <= bi;
        d_sh <= '0;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        a_sh <= a_nx;
        b_sh <= b_nx;
        d_sh <= d_nx;
        br   <= br_nx;
        cnt  <= cnt + 1'b1;
        // br is the borrow into the MSB on the final step (bi when WIDTH=1)
        if (last) begin
          diff <= d_nx;
          bout <= br_nx;
          ovf  <= br ^ br_nx;
          zero <= ~|d_nx;
        end
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Scoreboard bench: directed WIDTH=8 cases plus random vectors on WIDTH=1/8/32.
module tb_bit_serial_subtractor;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        st8, bi8, bo8, ov8, z8, bz8, dn8;
  logic [7:0]  a8, b8, d8;
  logic        st1, bi1, bo1, ov1, z1, bz1, dn1;
  logic [0:0]  a1, b1, d1;
  logic        st32, bi32, bo32, ov32, z32, bz32, dn32;
  logic [31:0] a32, b32, d32;

  bit_serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .ain(a8), .bin(b8), .bi(bi8),
    .diff(d8), .bout(bo8), .ovf(ov8), .zero(z8), .busy(bz8), .done(dn8));
  bit_serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .ain(a1), .bin(b1), .bi(bi1),
    .diff(d1), .bout(bo1), .ovf(ov1), .zero(z1), .busy(bz1), .done(dn1));
  bit_serial_subtractor #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(st32), .ain(a32), .bin(b32), .bi(bi32),
    .diff(d32), .bout(bo32), .ovf(ov32), .zero(z32), .busy(bz32), .done(dn32));

  exp_t q8[$], q1[$], q32[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: unsigned compare for borrow, signed range for overflow.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic c);
    exp_t   e;
    longint m, ua, ub, sa, sb, r, cl, hi;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    cl = c ? 1 : 0;
    hi = longint'(1) << (w - 1);
    sa = (ua >= hi) ? ua - (m + 1) : ua;
    sb = (ub >= hi) ? ub - (m + 1) : ub;
    r  = sa - sb - cl;
    e.d  = 32'((ua - ub - cl) & m);
    e.bo = (ua < ub + cl);
    e.ov = (r > hi - 1) || (r < -hi);
    e.z  = (e.d == 32'd0);
    return e;
  endfunction

  function automatic exp_t got_res(int w);
    exp_t g;
    case (w)
      1:       begin g.d = 32'(d1);  g.bo = bo1;  g.ov = ov1;  g.z = z1;  end
      8:       begin g.d = 32'(d8);  g.bo = bo8;  g.ov = ov8;  g.z = z8;  end
      default: begin g.d = d32;      g.bo = bo32; g.ov = ov32; g.z = z32; end
    endcase
    return g;
  endfunction

  function automatic logic done_of(int w);
    return (w == 1) ? dn1 : (w == 8) ? dn8 : dn32;
  endfunction

  task automatic cmp(string tag, exp_t g, exp_t e);
    chk({tag, "_diff"}, g.d, e.d);
    chk({tag, "_bout"}, 32'(g.bo), 32'(e.bo));
    chk({tag, "_ovf"},  32'(g.ov), 32'(e.ov));
    chk({tag, "_zero"}, 32'(g.z),  32'(e.z));
  endtask

  // One directed WIDTH=8 operation; cycles counted from the cycle start is driven.
  task automatic op8(string tag, logic [7:0] a, logic [7:0] b, logic c, exp_t e);
    int n;
    a8 = a; b8 = b; bi8 = c; st8 = 1'b1;
    q8.push_back(e);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      st8 = 1'b0;
    end while (!dn8 && n < 20);
    chk({tag, "_lat"}, 32'(n), 32'd9);
    cmp(tag, got_res(8), q8.pop_front());
  endtask

  task automatic rnd(int w);
    logic [31:0] a, b;
    logic        c;
    exp_t        e;
    int          n;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
      e = model(w, a, b, c);
      case (w)
        1:       begin a1 = a[0:0]; b1 = b[0:0]; bi1 = c; st1 = 1'b1; q1.push_back(e); end
        8:       begin a8 = a[7:0]; b8 = b[7:0]; bi8 = c; st8 = 1'b1; q8.push_back(e); end
        default: begin a32 = a; b32 = b; bi32 = c; st32 = 1'b1; q32.push_back(e); end
      endcase
      @(posedge clk); #1;
      // scramble inputs while shifting; latched operands must be unaffected
      case (w)
        1:       begin st1 = 1'b0; a1 = ~a1; b1 = ~b1; bi1 = ~c; end
        8:       begin st8 = 1'b0; a8 = ~a8; b8 = ~b8; bi8 = ~c; end
        default: begin st32 = 1'b0; a32 = ~a32; b32 = ~b32; bi32 = ~c; end
      endcase
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!done_of(w) && n < 40);
      chk($sformatf("r%0d_lat", w), 32'(n), 32'(w));
      case (w)
        1:       e = q1.pop_front();
        8:       e = q8.pop_front();
        default: e = q32.pop_front();
      endcase
      cmp($sformatf("r%0d", w), got_res(w), e);
    end
  endtask

  always @(negedge clk)
    if (mon_en) chk("excl", 32'((bz8 & dn8) | (bz1 & dn1) | (bz32 & dn32)), 32'd0);

  initial begin
    int   n, pulses;
    exp_t e;
    rst_n = 1'b0;
    st8 = 0; a8 = 0; b8 = 0; bi8 = 0;
    st1 = 0; a1 = 0; b1 = 0; bi1 = 0;
    st32 = 0; a32 = 0; b32 = 0; bi32 = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst", got_res(8), '{32'h0, 1'b0, 1'b0, 1'b0});
    chk("rst_busy", 32'(bz8), 32'd0);
    chk("rst_done", 32'(dn8), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    op8("sub",   8'h05, 8'h03, 1'b0, '{32'h02, 1'b0, 1'b0, 1'b0});
    op8("neg",   8'h03, 8'h05, 1'b0, '{32'hFE, 1'b1, 1'b0, 1'b0});
    op8("bin",   8'h00, 8'h00, 1'b1, '{32'hFF, 1'b1, 1'b0, 1'b0});
    op8("ovfa",  8'h80, 8'h01, 1'b0, '{32'h7F, 1'b0, 1'b1, 1'b0});
    op8("ovfb",  8'h7F, 8'hFF, 1'b0, '{32'h80, 1'b1, 1'b1, 1'b0});

    // start re-pulsed and operands changed mid-operation
    a8 = 8'h5A; b8 = 8'h5A; bi8 = 1'b0; st8 = 1'b1;
    q8.push_back('{32'h00, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1; st8 = 1'b0;
    chk("hold_diff", 32'(d8), 32'h80);
    repeat (2) @(posedge clk);
    #1; st8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; bi8 = 1'b1;
    repeat (2) @(posedge clk);
    #1; st8 = 1'b0;
    chk("hold_diff2", 32'(d8), 32'h80);
    n = 5;
    do begin @(posedge clk); #1; n++; end while (!dn8 && n < 20);
    chk("rep_lat", 32'(n), 32'd9);
    cmp("rep", got_res(8), q8.pop_front());
    pulses = 0;
    repeat (12) begin @(posedge clk); #1; if (dn8) pulses++; end
    chk("rep_pulses", 32'(pulses), 32'd0);

    // reset on the 4th SHIFT cycle
    a8 = 8'h33; b8 = 8'h11; bi8 = 1'b0; st8 = 1'b1;
    q8.push_back('{32'h22, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1; st8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 32'(bz8), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mr_busy", 32'(bz8), 32'd0);
    chk("mr_done", 32'(dn8), 32'd0);
    cmp("mr", got_res(8), '{32'h0, 1'b0, 1'b0, 1'b0});
    e = q8.pop_front();
    pulses = 0;
    repeat (15) begin @(posedge clk); #1; if (dn8) pulses++; end
    chk("mr_pulses", 32'(pulses), 32'd0);
    op8("post", 8'h33, 8'h11, 1'b0, e);

    // start held across DONE: back-to-back operations
    a8 = 8'h10; b8 = 8'h01; bi8 = 1'b0; st8 = 1'b1;
    q8.push_back('{32'h0F, 1'b0, 1'b0, 1'b0});
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!dn8 && n < 20);
    chk("b2b1_lat", 32'(n), 32'd9);
    cmp("b2b1", got_res(8), q8.pop_front());
    a8 = 8'h20; b8 = 8'h05;
    q8.push_back('{32'h1B, 1'b0, 1'b0, 1'b0});
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!dn8 && n < 20);
    st8 = 1'b0;
    chk("b2b2_gap", 32'(n), 32'd9);
    cmp("b2b2", got_res(8), q8.pop_front());
    @(posedge clk); #1;
    chk("b2b_idle", 32'(dn8 | bz8), 32'd0);

    fork
      rnd(1);
      rnd(8);
      rnd(32);
    join

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
